// File: rtl/toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_activity_monitor
//  Purpose  : Samples a set of netlist nets every clock, counts per-net
//             toggles over a fixed window of WINDOW cycles and streams the
//             per-window counts out over a valid/ready readout interface.
//             The result feeds per-cell switching activity to the thermal
//             and power estimator.
//  Ports    : clk         - sole clock, rising edge
//             rst_n       - asynchronous active-low reset, synchronous release
//             nets_i      - monitored net values (NUM_NETS bits)
//             enable_i    - level; high runs successive windows
//             rd_valid_o  - readout beat valid
//             rd_ready_i  - consumer accepts current beat
//             rd_idx_o    - net index of the current beat
//             rd_count_o  - toggle count for net rd_idx_o
//             rd_sat_o    - that count saturated during its window
//             rd_last_o   - beat is index NUM_NETS-1
//             overflow_o  - sticky: a finished window was dropped
//             busy_o      - counting FSM is in COUNT
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_activity_monitor #(
    parameter int NUM_NETS = 8,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_NETS-1:0]           nets_i,
    input  logic                          enable_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [$clog2(NUM_NETS)-1:0]   rd_idx_o,
    output logic [CNT_W-1:0]              rd_count_o,
    output logic                          rd_sat_o,
    output logic                          rd_last_o,
    output logic                          overflow_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_NETS);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NETS - 1);

    typedef enum logic [0:0] {
        C_IDLE  = 1'b0,
        C_COUNT = 1'b1
    } cstate_e;

    typedef enum logic [0:0] {
        D_IDLE  = 1'b0,
        D_DRAIN = 1'b1
    } dstate_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cstate_e                          cstate_q,  cstate_d;
    dstate_e                          dstate_q,  dstate_d;
    logic [NUM_NETS-1:0]              prev_q,    prev_d;
    logic [NUM_NETS-1:0][CNT_W-1:0]   cnt_q,     cnt_d;
    logic [NUM_NETS-1:0]              sat_q,     sat_d;
    logic [WIN_W-1:0]                 win_q,     win_d;
    logic [NUM_NETS-1:0][CNT_W-1:0]   shd_cnt_q, shd_cnt_d;
    logic [NUM_NETS-1:0]              shd_sat_q, shd_sat_d;
    logic [IDX_W-1:0]                 idx_q,     idx_d;
    logic                             ovf_q,     ovf_d;

    // ------------------------------------------------------------------
    // Per-net saturating increment of this cycle's toggles
    // ------------------------------------------------------------------
    logic [NUM_NETS-1:0]              toggle;
    logic [NUM_NETS-1:0][CNT_W-1:0]   cnt_inc;
    logic [NUM_NETS-1:0]              sat_inc;

    always_comb begin
        toggle  = nets_i ^ prev_q;
        cnt_inc = cnt_q;
        sat_inc = sat_q;
        for (int i = 0; i < NUM_NETS; i++) begin
            if (toggle[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_inc[i] = 1'b1;
                end else begin
                    cnt_inc[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Window-end / drain interaction
    // ------------------------------------------------------------------
    logic win_end;
    logic rd_hs;
    logic drain_done;
    logic snap_take;

    // A deasserted enable on the last window cycle aborts the window, so the
    // window only completes while enable is still high.
    assign win_end    = (cstate_q == C_COUNT) && enable_i && (win_q == WIN_LAST);
    assign rd_hs      = (dstate_q == D_DRAIN) && rd_ready_i;
    assign drain_done = rd_hs && (idx_q == IDX_LAST);
    // The shadow bank is free either when idle or when its final beat is
    // being accepted on this very cycle.
    assign snap_take  = win_end && ((dstate_q == D_IDLE) || drain_done);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cstate_d  = cstate_q;
        dstate_d  = dstate_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        win_d     = win_q;
        shd_cnt_d = shd_cnt_q;
        shd_sat_d = shd_sat_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q | (win_end && !snap_take);

        case (cstate_q)
            C_IDLE: begin
                if (enable_i) begin
                    // Entry cycle only primes the previous-sample register.
                    prev_d   = nets_i;
                    cnt_d    = '0;
                    sat_d    = '0;
                    win_d    = '0;
                    cstate_d = C_COUNT;
                end
            end
            C_COUNT: begin
                if (!enable_i) begin
                    cnt_d    = '0;
                    sat_d    = '0;
                    win_d    = '0;
                    cstate_d = C_IDLE;
                end else begin
                    prev_d = nets_i;
                    if (win_end) begin
                        cnt_d = '0;
                        sat_d = '0;
                        win_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        sat_d = sat_inc;
                        win_d = win_q + WIN_W'(1);
                    end
                end
            end
            default: cstate_d = C_IDLE;
        endcase

        if (snap_take) begin
            // Snapshot includes the toggles of the window-end cycle itself.
            shd_cnt_d = cnt_inc;
            shd_sat_d = sat_inc;
            idx_d     = '0;
            dstate_d  = D_DRAIN;
        end else if (rd_hs) begin
            if (idx_q == IDX_LAST) begin
                idx_d    = '0;
                dstate_d = D_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate_q  <= C_IDLE;
            dstate_q  <= D_IDLE;
            prev_q    <= '0;
            cnt_q     <= '0;
            sat_q     <= '0;
            win_q     <= '0;
            shd_cnt_q <= '0;
            shd_sat_q <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cstate_q  <= cstate_d;
            dstate_q  <= dstate_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            win_q     <= win_d;
            shd_cnt_q <= shd_cnt_d;
            shd_sat_q <= shd_sat_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived directly from registered state
    // ------------------------------------------------------------------
    assign rd_valid_o = (dstate_q == D_DRAIN);
    assign rd_idx_o   = idx_q;
    assign rd_count_o = shd_cnt_q[idx_q];
    assign rd_sat_o   = shd_sat_q[idx_q];
    assign rd_last_o  = (idx_q == IDX_LAST);
    assign overflow_o = ovf_q;
    assign busy_o     = (cstate_q == C_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_activity_monitor
//  Purpose  : Self-checking bench for toggle_activity_monitor with
//             NUM_NETS=4, CNT_W=3, WINDOW=8. Expected readout beats are
//             queued by the stimulus; a negedge monitor compares every
//             presented beat against the head of the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_activity_monitor;

    localparam int NUM_NETS = 4;
    localparam int CNT_W    = 3;
    localparam int WINDOW   = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       nets_i;
    logic             enable_i;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [1:0]       rd_idx_o;
    logic [2:0]       rd_count_o;
    logic             rd_sat_o;
    logic             rd_last_o;
    logic             overflow_o;
    logic             busy_o;

    toggle_activity_monitor #(
        .NUM_NETS (NUM_NETS),
        .CNT_W    (CNT_W),
        .WINDOW   (WINDOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nets_i     (nets_i),
        .enable_i   (enable_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_idx_o   (rd_idx_o),
        .rd_count_o (rd_count_o),
        .rd_sat_o   (rd_sat_o),
        .rd_last_o  (rd_last_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] cnt;
        logic       sat;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    k      = 0;
    logic [3:0] pat = 4'b0000;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Net i toggles with a fixed period relative to the window entry:
    // net0 every 2 cycles (4/window), net1 every cycle (8/window, saturates),
    // net2 every 4 cycles (2/window), net3 every 8 cycles (1/window).
    function automatic logic [3:0] f(input int kk);
        logic [31:0] kv;
        kv = kk;
        return {pat[3] & kv[3], pat[2] & kv[2], pat[1] & kv[0], pat[0] & kv[1]};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        k++;
        nets_i = f(k);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Called just after a rising edge; the next edge is the IDLE->COUNT entry.
    task automatic start(input logic [3:0] p);
        pat      = p;
        k        = 0;
        nets_i   = f(0);
        enable_i = 1'b1;
    endtask

    task automatic push_window(input logic [2:0] c0, input logic [2:0] c1,
                               input logic [2:0] c2, input logic [2:0] c3,
                               input logic [3:0] s);
        logic [2:0] c [4];
        beat_t b;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            b.idx  = 2'(i);
            b.cnt  = c[i];
            b.sat  = s[i];
            b.last = (i == 3);
            exp_q.push_back(b);
        end
    endtask

    // Scoreboard monitor: every cycle with a valid beat is compared to the
    // queue head (covering hold under backpressure); accepted beats pop.
    always @(negedge clk) begin
        if (rst_n && rd_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got idx %0d count %0d, required no beat (t=%0t)",
                         rd_idx_o, rd_count_o, $time);
            end else begin
                mon_e = exp_q[0];
                chk("beat_idx",   32'(rd_idx_o),   32'(mon_e.idx));
                chk("beat_count", 32'(rd_count_o), 32'(mon_e.cnt));
                chk("beat_sat",   32'(rd_sat_o),   32'(mon_e.sat));
                chk("beat_last",  32'(rd_last_o),  32'(mon_e.last));
                if (rd_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        rd_ready_i = 1'b0;
        nets_i     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",    32'(rd_valid_o), 0);
        chk("rst_idx",      32'(rd_idx_o),   0);
        chk("rst_count",    32'(rd_count_o), 0);
        chk("rst_sat",      32'(rd_sat_o),   0);
        chk("rst_last",     32'(rd_last_o),  0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_busy",     32'(busy_o),     0);
        rst_n = 1'b1;
        run(2);

        // ---------------- basic count ----------------
        rd_ready_i = 1'b1;
        push_window(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000);
        start(4'b0001);
        run(8);
        chk("basic_busy",        32'(busy_o),     1);
        chk("basic_valid_early", 32'(rd_valid_o), 0);
        run(1);
        chk("basic_valid_n1",    32'(rd_valid_o), 1);
        chk("basic_idx0",        32'(rd_idx_o),   0);
        enable_i = 1'b0;
        run(6);
        chk("basic_busy_off",    32'(busy_o),     0);
        chk("basic_valid_off",   32'(rd_valid_o), 0);
        chk("basic_drained",     exp_q.size(),    0);

        // ---------------- saturation, two windows ----------------
        push_window(3'd0, 3'd7, 3'd0, 3'd0, 4'b0010);
        push_window(3'd0, 3'd7, 3'd0, 3'd0, 4'b0010);
        start(4'b0010);
        run(17);
        enable_i = 1'b0;
        run(6);
        chk("sat_drained",   exp_q.size(),    0);
        chk("sat_valid_off", 32'(rd_valid_o), 0);

        // ---------------- simultaneous last beat / window end ----------------
        rd_ready_i = 1'b0;
        push_window(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000);
        push_window(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000);
        start(4'b0001);
        run(13);
        chk("sim_held_valid", 32'(rd_valid_o), 1);
        chk("sim_held_idx",   32'(rd_idx_o),   0);
        rd_ready_i = 1'b1;
        run(4);
        chk("sim_valid_kept", 32'(rd_valid_o), 1);
        chk("sim_idx_wrap",   32'(rd_idx_o),   0);
        chk("sim_no_ovf",     32'(overflow_o), 0);
        enable_i = 1'b0;
        run(6);
        chk("sim_drained",    exp_q.size(),    0);

        // ---------------- abort ----------------
        start(4'b0001);
        run(5);
        chk("abort_busy_on",  32'(busy_o), 1);
        enable_i = 1'b0;
        run(1);
        chk("abort_busy_off", 32'(busy_o), 0);
        run(10);
        chk("abort_no_valid", 32'(rd_valid_o), 0);
        push_window(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000);
        start(4'b0001);
        run(9);
        enable_i = 1'b0;
        run(6);
        chk("abort_drained",  exp_q.size(), 0);

        // ---------------- backpressure / overflow ----------------
        rd_ready_i = 1'b0;
        push_window(3'd0, 3'd0, 3'd2, 3'd0, 4'b0000);
        start(4'b0100);
        run(9);
        chk("bp_valid",      32'(rd_valid_o), 1);
        chk("bp_ovf_before", 32'(overflow_o), 0);
        run(20);
        chk("bp_ovf_set",    32'(overflow_o), 1);
        chk("bp_idx_held",   32'(rd_idx_o),   0);
        enable_i   = 1'b0;
        rd_ready_i = 1'b1;
        run(6);
        chk("bp_drained",    exp_q.size(),    0);
        chk("bp_valid_off",  32'(rd_valid_o), 0);
        chk("bp_ovf_sticky", 32'(overflow_o), 1);

        // ---------------- reset mid-drain ----------------
        push_window(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000);
        start(4'b0001);
        run(11);
        chk("rmd_idx2",     32'(rd_idx_o),   2);
        chk("rmd_ovf_held", 32'(overflow_o), 1);
        rd_ready_i = 1'b0;
        #2;
        rst_n    = 1'b0;
        enable_i = 1'b0;
        #1;
        chk("rmd_valid", 32'(rd_valid_o), 0);
        chk("rmd_ovf",   32'(overflow_o), 0);
        chk("rmd_busy",  32'(busy_o),     0);
        chk("rmd_idx",   32'(rd_idx_o),   0);
        exp_q.delete();
        run(2);
        rst_n = 1'b1;
        run(1);
        rd_ready_i = 1'b1;
        push_window(3'd0, 3'd0, 3'd2, 3'd0, 4'b0000);
        start(4'b0100);
        run(9);
        chk("rmd_after_valid", 32'(rd_valid_o), 1);
        enable_i = 1'b0;
        run(6);
        chk("rmd_drained",     exp_q.size(),    0);
        chk("rmd_ovf_clear",   32'(overflow_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
